// File: rtl/multiword_adder_ctrl.sv
// Multi-cycle wide adder: adds two WORDS*LENGTH-bit operands one LENGTH-bit slice per cycle, LSB slice first.
// Optional macro MULTIWORD_ADDER_CTRL_CIN_EN adds a carry_i input sampled with the operands.

module multiword_adder_ctrl_rca #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// start_ready_o is high only in IDLE, done_valid_o only in DONE, and sum_o/carry_o are held while done_valid_o=1.
module multiword_adder_ctrl #(
  parameter int unsigned LENGTH = 16,
  parameter int unsigned WORDS  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_valid_i,
  output logic                      start_ready_o,
  input  logic [WORDS*LENGTH-1:0]   a_i,
  input  logic [WORDS*LENGTH-1:0]   b_i,
`ifdef MULTIWORD_ADDER_CTRL_CIN_EN
  input  logic                      carry_i,
`endif
  output logic [WORDS*LENGTH-1:0]   sum_o,
  output logic                      carry_o,
  output logic                      done_valid_o,
  input  logic                      done_ready_i,
  output logic                      busy_o,
  output logic [1:0]                dbg_state_o
);
  localparam int unsigned W     = WORDS * LENGTH;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               carry_out_q;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic               carry_init;
  logic               accept, last_slice;

  logic [LENGTH-1:0]  a_slice, b_slice, part_sum, slice_sum;
  logic               c_first, c_second, slice_carry;

`ifdef MULTIWORD_ADDER_CTRL_CIN_EN
  assign carry_init = carry_i;
`else
  assign carry_init = 1'b0;
`endif

  assign accept     = (state_q == IDLE) && start_valid_i;
  assign last_slice = (idx_q == IDX_W'(WORDS - 1));

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_slice = a_q[i*LENGTH +: LENGTH];
        b_slice = b_q[i*LENGTH +: LENGTH];
      end
    end
  end

  multiword_adder_ctrl_rca #(.N(LENGTH)) u_add_ab (
    .a    (a_slice),
    .b    (b_slice),
    .sum  (part_sum),
    .cout (c_first)
  );

  // The partial sum can only overflow again when the first add did not, so OR is exact.
  multiword_adder_ctrl_rca #(.N(LENGTH)) u_add_c (
    .a    (part_sum),
    .b    (LENGTH'(carry_q)),
    .sum  (slice_sum),
    .cout (c_second)
  );

  assign slice_carry = c_first | c_second;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    start_ready_o = 1'b0;
    busy_o        = 1'b0;
    done_valid_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) state_d = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        done_valid_o = 1'b1;
        if (done_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
    end else if (accept) begin
      a_q     <= a_i;
      b_q     <= b_i;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= carry_init;
    end else if (state_q == RUN) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        if (idx_q == IDX_W'(i)) sum_q[i*LENGTH +: LENGTH] <= slice_sum;
      end
      carry_q <= slice_carry;
      if (last_slice) begin
        carry_out_q <= slice_carry;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign sum_o       = sum_q;
  assign carry_o     = carry_out_q;
  assign dbg_state_o = state_q;
endmodule
